// File: rtl/bsg_relay_fifo_els.sv
// Relay FIFO of els_p entries with fully registered handshake outputs, occupancy
// count, almost-full flag and synchronous clear.
module bsg_relay_fifo_els #(
    parameter int unsigned width_p          = 16,
    parameter int unsigned els_p            = 4,
    parameter int unsigned almost_full_lo_p = els_p - 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         clear_i,
    input  logic                         v_i,
    input  logic [width_p-1:0]           data_i,
    output logic                         ready_o,
    output logic                         v_o,
    output logic [width_p-1:0]           data_o,
    input  logic                         ready_i,
    output logic [$clog2(els_p+1)-1:0]   count_o,
    output logic                         almost_full_o
);

    localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned cnt_w_lp = $clog2(els_p + 1);

    if (width_p < 1) begin : g_bad_width
        $error("bsg_relay_fifo_els: width_p must be >= 1");
    end
    if (els_p < 2) begin : g_bad_els
        $error("bsg_relay_fifo_els: els_p must be >= 2");
    end
    if (almost_full_lo_p < 1 || almost_full_lo_p > els_p) begin : g_bad_af
        $error("bsg_relay_fifo_els: almost_full_lo_p must be in 1..els_p");
    end

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] wptr_r, wptr_n;
    logic [ptr_w_lp-1:0] rptr_r, rptr_n;
    logic [cnt_w_lp-1:0] count_r, count_n;
    logic                full_r, full_n;
    logic                empty_r, empty_n;
    logic                af_r, af_n;
    logic                enq_c, deq_c;

    // Handshakes use only registered flags, so no input reaches ready_o/v_o.
    assign enq_c = v_i & ~full_r;
    assign deq_c = ~empty_r & ready_i;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    always_comb begin
        wptr_n  = wptr_r;
        rptr_n  = rptr_r;
        count_n = count_r;
        if (clear_i) begin
            wptr_n  = '0;
            rptr_n  = '0;
            count_n = '0;
        end else begin
            if (enq_c) wptr_n = ptr_inc(wptr_r);
            if (deq_c) rptr_n = ptr_inc(rptr_r);
            unique case ({enq_c, deq_c})
                2'b10:   count_n = count_r + cnt_w_lp'(1);
                2'b01:   count_n = count_r - cnt_w_lp'(1);
                default: count_n = count_r;
            endcase
        end
        full_n  = (count_n == cnt_w_lp'(els_p));
        empty_n = (count_n == '0);
        af_n    = (count_n >= cnt_w_lp'(almost_full_lo_p));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            af_r    <= 1'b0;
        end else begin
            wptr_r  <= wptr_n;
            rptr_r  <= rptr_n;
            count_r <= count_n;
            full_r  <= full_n;
            empty_r <= empty_n;
            af_r    <= af_n;
        end
    end

    // Storage needs no reset; occupancy flags guard every read.
    always_ff @(posedge clk_i) begin
        if (enq_c && !clear_i && !reset_i) begin
            mem_r[wptr_r] <= data_i;
        end
    end

    assign ready_o       = ~full_r;
    assign v_o           = ~empty_r;
    assign data_o        = mem_r[rptr_r];
    assign count_o       = count_r;
    assign almost_full_o = af_r;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (count_r <= cnt_w_lp'(els_p))
                else $error("bsg_relay_fifo_els: occupancy above els_p");
            assert (!(full_r && empty_r))
                else $error("bsg_relay_fifo_els: full and empty together");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_relay_fifo_els.sv
// Bench for bsg_relay_fifo_els: four depths (4,3,2,8) share one stimulus stream,
// checked against directed expectations and a per-depth queue model.
module tb_bsg_relay_fifo_els;

    localparam int unsigned W = 16;

    logic          clk = 1'b0;
    logic          reset_i, clear_i, v_i, ready_i;
    logic [W-1:0]  data_i;

    logic          ready_a [4];
    logic          v_a     [4];
    logic          af_a    [4];
    logic [W-1:0]  data_a  [4];
    logic [3:0]    cnt_a   [4];

    always #5 clk = ~clk;

    function automatic int unsigned els_of(input int i);
        case (i)
            0:       return 4;
            1:       return 3;
            2:       return 2;
            default: return 8;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned E = els_of(g);
        logic [$clog2(E+1)-1:0] cnt;
        bsg_relay_fifo_els #(.width_p(W), .els_p(E)) dut (
            .clk_i         (clk),
            .reset_i       (reset_i),
            .clear_i       (clear_i),
            .v_i           (v_i),
            .data_i        (data_i),
            .ready_o       (ready_a[g]),
            .v_o           (v_a[g]),
            .data_o        (data_a[g]),
            .ready_i       (ready_i),
            .count_o       (cnt),
            .almost_full_o (af_a[g])
        );
        assign cnt_a[g] = 4'(cnt);
    end

    int checks   = 0;
    int failures = 0;

    // Reference model: circular buffer of capacity 8, bounded per depth.
    logic [W-1:0] mq [4][8];
    int           mh [4];
    int           mc [4];
    int           deq_cnt [4];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Check all outputs against the model, advance the model, then clock once.
    task automatic step();
        for (int i = 0; i < 4; i++) begin
            int e;
            e = int'(els_of(i));
            check_eq($sformatf("v_o[%0d]", i),     32'(v_a[i]),     32'(mc[i] > 0));
            check_eq($sformatf("ready_o[%0d]", i), 32'(ready_a[i]), 32'(mc[i] < e));
            check_eq($sformatf("count_o[%0d]", i), 32'(cnt_a[i]),   32'(mc[i]));
            check_eq($sformatf("af_o[%0d]", i),    32'(af_a[i]),    32'(mc[i] >= e - 1));
            if (mc[i] > 0)
                check_eq($sformatf("data_o[%0d]", i), 32'(data_a[i]), 32'(mq[i][mh[i]]));
        end
        for (int i = 0; i < 4; i++) begin
            int  e, tail;
            logic enq, deq;
            e    = int'(els_of(i));
            enq  = v_i && (mc[i] < e);
            deq  = (mc[i] > 0) && ready_i;
            tail = (mh[i] + mc[i]) % 8;
            if (reset_i || clear_i) begin
                if (deq && !reset_i) deq_cnt[i]++;
                mh[i] = 0;
                mc[i] = 0;
            end else begin
                if (enq) mq[i][tail] = data_i;
                if (deq) begin
                    mh[i] = (mh[i] + 1) % 8;
                    mc[i]--;
                    deq_cnt[i]++;
                end
                if (enq) mc[i]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        v_i    = 1'b1;
        data_i = d;
        step();
        v_i    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic randomize_inputs(input int clear_pct);
        v_i     = 1'($urandom_range(0, 1));
        ready_i = 1'($urandom_range(0, 1));
        clear_i = (clear_pct > 0) && (int'($urandom_range(0, 99)) < clear_pct);
        data_i  = 16'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            mh[i] = 0; mc[i] = 0; deq_cnt[i] = 0;
        end
        reset_i = 1'b1; clear_i = 1'b0; v_i = 1'b0; ready_i = 1'b0; data_i = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_i = 1'b0;

        check_eq("rst_v",     32'(v_a[0]),     32'd0);
        check_eq("rst_ready", 32'(ready_a[0]), 32'd1);
        check_eq("rst_count", 32'(cnt_a[0]),   32'd0);
        check_eq("rst_af",    32'(af_a[0]),    32'd0);

        // Fill depth 4 with 1..4, no consumer.
        ready_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            push(16'(k));
            check_eq("fill_count", 32'(cnt_a[0]), 32'(k));
            check_eq("fill_af",    32'(af_a[0]),  32'(k >= 3));
        end
        check_eq("fill_ready", 32'(ready_a[0]), 32'd0);

        // Drain in order.
        ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check_eq("drain_data", 32'(data_a[0]), 32'(k));
            check_eq("drain_v",    32'(v_a[0]),    32'd1);
            step();
        end
        check_eq("drain_v_end",     32'(v_a[0]),   32'd0);
        check_eq("drain_count_end", 32'(cnt_a[0]), 32'd0);

        // Streaming through depth 3.
        deq_cnt[1] = 0;
        v_i = 1'b1; ready_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            data_i = 16'(16'h0100 + k);
            step();
        end
        v_i = 1'b0;
        check_eq("stream_tput", 32'(deq_cnt[1]), 32'd19);
        idle(2);

        // Full plus deq: enq blocked in that cycle.
        ready_i = 1'b0;
        for (int k = 1; k <= 4; k++) push(16'(16'h0200 + k));
        v_i = 1'b1; ready_i = 1'b1; data_i = 16'h02FF;
        check_eq("full_blk_ready", 32'(ready_a[0]), 32'd0);
        step();
        v_i = 1'b0;
        check_eq("full_deq_count", 32'(cnt_a[0]),   32'd3);
        check_eq("full_deq_ready", 32'(ready_a[0]), 32'd1);
        for (int k = 2; k <= 4; k++) begin
            check_eq("full_drain_data", 32'(data_a[0]), 32'(16'h0200 + k));
            step();
        end
        check_eq("full_drain_v", 32'(v_a[0]), 32'd0);
        idle(8);

        // Clear with count 2 and a colliding enq.
        ready_i = 1'b0;
        push(16'h0301);
        push(16'h0302);
        check_eq("clr_pre_count", 32'(cnt_a[0]), 32'd2);
        clear_i = 1'b1; v_i = 1'b1; data_i = 16'hBEEF;
        step();
        clear_i = 1'b0; v_i = 1'b0;
        check_eq("clr_count", 32'(cnt_a[0]), 32'd0);
        check_eq("clr_v",     32'(v_a[0]),   32'd0);
        push(16'h1234);
        check_eq("clr_next_v",    32'(v_a[0]),    32'd1);
        check_eq("clr_next_data", 32'(data_a[0]), 32'h1234);
        ready_i = 1'b1;
        step();
        check_eq("clr_next_drained", 32'(v_a[0]), 32'd0);

        // Random traffic, then reset at count 3.
        for (int k = 0; k < 50; k++) begin
            randomize_inputs(0);
            step();
        end
        v_i = 1'b0; ready_i = 1'b1;
        idle(9);
        ready_i = 1'b0;
        for (int k = 1; k <= 3; k++) push(16'(16'h0500 + k));
        check_eq("rst_mid_count", 32'(cnt_a[0]), 32'd3);
        reset_i = 1'b1; v_i = 1'b1; ready_i = 1'b1; data_i = 16'h4444;
        step();
        reset_i = 1'b0; v_i = 1'b0; ready_i = 1'b0;
        check_eq("rst_mid_v",     32'(v_a[0]),     32'd0);
        check_eq("rst_mid_ready", 32'(ready_a[0]), 32'd1);
        check_eq("rst_mid_count0",32'(cnt_a[0]),   32'd0);
        check_eq("rst_mid_af",    32'(af_a[0]),    32'd0);
        idle(2);

        // Long random backpressure with occasional clear.
        for (int k = 0; k < 2000; k++) begin
            randomize_inputs(1);
            step();
        end
        clear_i = 1'b0; v_i = 1'b0; ready_i = 1'b1;
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bsg_relay_fifo_els.md
# bsg_relay_fifo_els

Parametrised relay FIFO: a registered ready/valid buffer with configurable width and depth, an occupancy count, an almost-full flag and a synchronous clear. It sits between two ready/valid endpoints on long or congested paths. Combinational paths are fully cut: `ready_o` and `v_o` depend only on state. Generalises the fixed two-element, width-16 relay to any `els_p >= 2`, including non-power-of-two depths.

## Interface
- `width_p`, default 16: data width in bits, must be >= 1.
- `els_p`, default 4: number of entries, must be >= 2; power of two not required.
- `almost_full_lo_p`, default `els_p-1`: occupancy threshold at which `almost_full_o` asserts; legal range 1..`els_p`.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `reset_i`  in  1  reset, synchronous, active-high.
- `clear_i`  in  1  synchronous flush; discards all stored entries.
- `v_i`  in  1  producer valid.
- `data_i`  in  `width_p`  producer data.
- `ready_o`  out  1  FIFO can accept; equals not-full; independent of `v_i`, `ready_i` and `clear_i`.
- `v_o`  out  1  head entry valid; equals not-empty.
- `data_o`  out  `width_p`  head entry; undefined while `v_o`=0.
- `ready_i`  in  1  consumer ready.
- `count_o`  out  `$clog2(els_p+1)`  current occupancy, 0..`els_p`.
- `almost_full_o`  out  1  high when `count_o` >= `almost_full_lo_p`.

## Operation
- Handshake events:
  - enq = `v_i & ready_o`.
  - deq = `v_o & ready_i`. The internal yumi is formed from `ready_i`; consumers need not gate it.
- Storage is an `els_p` x `width_p` register array written at the tail pointer, with a combinational read at the head pointer.
- Pointers:
  - `wptr`/`rptr` each range 0..`els_p-1`.
  - On advance, a pointer at `els_p-1` wraps to 0; no power-of-two masking.
- Full and empty are tracked in registered flags (or derived from a registered count); no pointer-equality ambiguity is allowed.
- Next state with `clear_i`=0:
  - enq only: write `data_i` at `wptr`, advance `wptr`, count+1.
  - deq only: advance `rptr`, count-1.
  - enq and deq together: legal only when 0 < count < `els_p`. Both pointers advance and count is unchanged.
  - When full, enq cannot occur (`ready_o`=0), even if deq happens in the same cycle. There is no same-cycle pass-through of freed space.
  - When empty, deq cannot occur. Data enqueued into an empty FIFO appears on `data_o`/`v_o` in the next cycle, never in the same cycle.
- `clear_i`=1 (with `reset_i`=0):
  - Next state is empty: pointers 0, count 0.
  - A same-cycle enq is dropped.
  - A same-cycle deq still counts as taken by the consumer (`data_o` was valid), but causes no further state change.
- `reset_i` dominates `clear_i` and can be asserted at any time, including mid-burst. All state returns to the reset values; memory contents need not be cleared.
- `count_o` and `almost_full_o` are derived from registered state only.

## Timing
- Reset values (cycle after `reset_i` is sampled high): `v_o`=0, `ready_o`=1, `count_o`=0, `almost_full_o`=0, `data_o` don't-care.
- Latency is 1 cycle from enq to `v_o`=1 when the FIFO was empty.
- Throughput is 1 transfer per cycle in steady state, for any `els_p` >= 2.
- `ready_o` falls in the cycle after the enq that makes count = `els_p`. It rises in the cycle after the first deq from full.
- `almost_full_o` updates in the same cycle as `count_o`.
- No combinational path exists from any input to `ready_o`, `v_o`, `count_o` or `almost_full_o`. `data_o` depends only on state.
- Assertions (simulation only):
  - `v_i`=1 with `ready_o`=0 is permitted: data is held and retried by the producer.
  - Parameter ranges are checked at elaboration.

## Test plan
- Reset/fill/drain, `els_p`=4: reset, then push 0x0001..0x0004 with `ready_i`=0.
  - Expect `ready_o`=0 after the 4th enq, `count_o`=4, and `almost_full_o`=1 from count 3.
  - Then `ready_i`=1: `data_o` returns 0x0001..0x0004 in order, `v_o` drops after the 4th deq, `count_o`=0.
- Streaming with wrap, `els_p`=3 (non-power-of-two): `v_i` and `ready_i` held high for 20 cycles with an incrementing pattern.
  - Expect one transfer per cycle after the 1-cycle fill latency, in order with no loss or duplication, across ≥6 pointer wraps.
- Full plus deq: fill to `els_p`, then assert `v_i`=1 and `ready_i`=1 in the same cycle.
  - Expect the enq blocked that cycle (`ready_o`=0), `count_o`=`els_p`-1 next cycle, then `ready_o`=1.
- Clear mid-operation: with count=2, assert `clear_i` together with `v_i`=1 (data 0xBEEF).
  - Expect `count_o`=0 and `v_o`=0 next cycle.
  - 0xBEEF is never output; the next enqueued word appears first.
- Reset during traffic: random `v_i`/`ready_i` for 50 cycles, then assert `reset_i` for 1 cycle at count=3.
  - Expect the reset values next cycle, with a scoreboard restarted and clean afterwards.
- Random backpressure: 2000 cycles of random `v_i`/`ready_i`/`clear_i` (1%) for `els_p` in {2,3,8}.
  - The scoreboard must match exactly.
  - `count_o` must always equal the model occupancy; `almost_full_o` must be consistent with it.
